// File: rtl/wait_event_pkg.sv
// Shared types and constants for the wait-event arbiter.
// Optional feature macro: WAIT_EVENT_ARB_WATCHDOG_EN (see wait_event_arbiter.sv).
package wait_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Extra cycles the watchdog allows beyond the requester's own timeout.
  localparam int unsigned WD_MARGIN = 16;

endpackage

// File: rtl/wait_event_rr_arbiter.sv
// Combinational round-robin pick: the first active request found
// searching upward from i_last+1 (wrapping) wins.
module wait_event_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [IW-1:0]    o_idx,
  output logic             o_valid
);

  // Scan candidates last+1 .. last+N_REQ modulo N_REQ; first hit wins.
  always_comb begin
    int unsigned cand;
    o_idx   = '0;
    o_valid = 1'b0;
    cand    = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(i_last) + k) % N_REQ;
      if (!o_valid && i_req[IW'(cand)]) begin
        o_valid = 1'b1;
        o_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/wait_event_arbiter.sv
// Round-robin arbiter sharing one wait-event resource among N_REQ requesters.
// Optional watchdog: define WAIT_EVENT_ARB_WATCHDOG_EN to abort a wait after
// o_max_timeout+WD_MARGIN cycles with o_err=1. Without it o_err is tied low.
module wait_event_arbiter
  import wait_event_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WAIT_SIZE = 5,
  parameter int unsigned TO_WIDTH  = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_REQ-1:0]                     i_req,
  input  logic [N_REQ*$clog2(WAIT_SIZE)-1:0]   i_req_sel,
  input  logic [N_REQ-1:0]                     i_req_edge,
  input  logic [N_REQ*TO_WIDTH-1:0]            i_req_timeout,
  output logic [N_REQ-1:0]                     o_gnt,
  output logic [N_REQ-1:0]                     o_done,
  output logic                                 o_err,
  output logic                                 o_wait_en,
  output logic [$clog2(WAIT_SIZE)-1:0]         o_wait_sel,
  output logic                                 o_sel_wtr_wtf,
  output logic [TO_WIDTH-1:0]                  o_max_timeout,
  input  logic                                 i_wait_done,
  output logic                                 o_busy
);

  localparam int unsigned SW = $clog2(WAIT_SIZE);
  localparam int unsigned IW = $clog2(N_REQ);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] winner, last_winner;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          wd_expired;

  logic [SW-1:0]       sel_arr [N_REQ];
  logic [TO_WIDTH-1:0] to_arr  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign sel_arr[g] = i_req_sel[g*SW +: SW];
    assign to_arr[g]  = i_req_timeout[g*TO_WIDTH +: TO_WIDTH];
  end

  wait_event_rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .i_req   (i_req),
    .i_last  (last_winner),
    .o_idx   (pick_idx),
    .o_valid (pick_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (pick_valid) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = ST_WAIT;
      ST_WAIT:  if (i_wait_done || wd_expired) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Winner and its configuration are captured when leaving IDLE so they are
  // already valid during the GRANT cycle and stay stable through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner        <= '0;
      last_winner   <= IW'(N_REQ - 1);
      o_wait_sel    <= '0;
      o_sel_wtr_wtf <= 1'b0;
      o_max_timeout <= '0;
    end else begin
      if (state == ST_IDLE && pick_valid) begin
        winner        <= pick_idx;
        o_wait_sel    <= sel_arr[pick_idx];
        o_sel_wtr_wtf <= i_req_edge[pick_idx];
        o_max_timeout <= to_arr[pick_idx];
      end
      if (state == ST_RESP) last_winner <= winner;
    end
  end

`ifdef WAIT_EVENT_ARB_WATCHDOG_EN
  localparam int unsigned CW = TO_WIDTH + 1;
  logic [TO_WIDTH:0] wd_cnt;
  logic              wd_err;

  assign wd_expired = (wd_cnt == ({1'b0, o_max_timeout} + CW'(WD_MARGIN)));

  // Cycle counter: cleared on WAIT entry, counts each WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wd_cnt <= '0;
    else if (state == ST_GRANT)  wd_cnt <= '0;
    else if (state == ST_WAIT)   wd_cnt <= wd_cnt + 1'b1;
  end

  // Error flag for the following RESP; a same-cycle done wins over expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wd_err <= 1'b0;
    else if (state == ST_WAIT)  wd_err <= wd_expired && !i_wait_done;
  end

  assign o_err = (state == ST_RESP) && wd_err;
`else
  assign wd_expired = 1'b0;
  assign o_err      = 1'b0;
`endif

  // State-decoded outputs; all are zero in IDLE, hence zero under reset.
  always_comb begin
    o_gnt     = '0;
    o_done    = '0;
    o_wait_en = (state == ST_WAIT);
    o_busy    = (state != ST_IDLE);
    if (state == ST_GRANT) o_gnt  = N_REQ'(1) << winner;
    if (state == ST_RESP)  o_done = N_REQ'(1) << winner;
  end

endmodule

// File: tb/tb_wait_event_arbiter.sv
// Directed self-checking bench for wait_event_arbiter (N_REQ=4, WAIT_SIZE=5).
// Watchdog expectations follow WAIT_EVENT_ARB_WATCHDOG_EN.
module tb_wait_event_arbiter;

  localparam int N  = 4;
  localparam int SW = 3;
  localparam int TW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    i_req;
  logic [N*SW-1:0] i_req_sel;
  logic [N-1:0]    i_req_edge;
  logic [N*TW-1:0] i_req_timeout;
  logic [N-1:0]    o_gnt, o_done;
  logic            o_err, o_wait_en, o_sel_wtr_wtf, o_busy;
  logic [SW-1:0]   o_wait_sel;
  logic [TW-1:0]   o_max_timeout;
  logic            i_wait_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wait_event_arbiter #(
    .N_REQ     (4),
    .WAIT_SIZE (5),
    .TO_WIDTH  (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (i_req),
    .i_req_sel     (i_req_sel),
    .i_req_edge    (i_req_edge),
    .i_req_timeout (i_req_timeout),
    .o_gnt         (o_gnt),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_wait_en     (o_wait_en),
    .o_wait_sel    (o_wait_sel),
    .o_sel_wtr_wtf (o_sel_wtr_wtf),
    .o_max_timeout (o_max_timeout),
    .i_wait_done   (i_wait_done),
    .o_busy        (o_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = '0;
    i_wait_done = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Step until a grant appears; an expired budget is a failed comparison.
  task automatic wait_gnt(input string name);
    int n = 0;
    while (o_gnt == '0 && n < 50) begin
      tick();
      n++;
    end
    n_cmp++;
    if (o_gnt == '0) begin
      n_bad++;
      $display("FAIL %s_grant_timeout: no grant after %0d cycles, required within 50", name, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_req = '0;
    i_wait_done = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({o_gnt, o_done, o_err, o_wait_en, o_busy, o_sel_wtr_wtf} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got gnt=%b done=%b err=%b en=%b busy=%b edge=%b, required all 0",
               o_gnt, o_done, o_err, o_wait_en, o_busy, o_sel_wtr_wtf);
    end
    n_cmp++;
    if (o_wait_sel !== '0 || o_max_timeout !== '0) begin
      n_bad++;
      $display("FAIL reset_cfg: got sel=%0d to=%0d, required 0/0", o_wait_sel, o_max_timeout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    i_req = 4'b0001;
    tick();
    n_cmp++;
    if (o_gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_gnt_latency: got %b, required 0001", o_gnt);
    end
    n_cmp++;
    if (o_wait_sel !== 3'd3 || o_sel_wtr_wtf !== 1'b1 || o_max_timeout !== 32'd100) begin
      n_bad++;
      $display("FAIL single_cfg: got sel=%0d edge=%b to=%0d, required 3/1/100",
               o_wait_sel, o_sel_wtr_wtf, o_max_timeout);
    end
    i_req = '0;
    repeat (19) tick();
    n_cmp++;
    if (o_wait_en !== 1'b1 || o_done !== '0 || o_wait_sel !== 3'd3) begin
      n_bad++;
      $display("FAIL single_wait: got en=%b done=%b sel=%0d, required 1/0000/3",
               o_wait_en, o_done, o_wait_sel);
    end
    i_wait_done = 1'b1;
    tick();
    i_wait_done = 1'b0;
    n_cmp++;
    if (o_done !== 4'b0001 || o_err !== 1'b0 || o_wait_en !== 1'b0) begin
      n_bad++;
      $display("FAIL single_done: got done=%b err=%b en=%b, required 0001/0/0",
               o_done, o_err, o_wait_en);
    end
    tick();
    n_cmp++;
    if (o_busy !== 1'b0 || o_done !== '0) begin
      n_bad++;
      $display("FAIL single_idle: got busy=%b done=%b, required 0/0000", o_busy, o_done);
    end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp;
    do_reset();
    i_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << exp_order[k];
      wait_gnt("rr");
      n_cmp++;
      if (o_gnt !== exp || o_wait_en !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_gnt%0d: got gnt=%b en=%b, required %b/0", k, o_gnt, o_wait_en, exp);
      end
      repeat (4) tick();
      i_wait_done = 1'b1;
      tick();
      i_wait_done = 1'b0;
      n_cmp++;
      if (o_done !== exp || o_wait_en !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_done%0d: got done=%b en=%b, required %b/0", k, o_done, o_wait_en, exp);
      end
      tick();
      n_cmp++;
      if (o_wait_en !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_idle_gap%0d: got en=%b, required 0", k, o_wait_en);
      end
    end
    i_req = '0;
    repeat (3) tick();
  endtask

  task automatic test_watchdog();
    int n = 0;
    do_reset();
    i_req = 4'b0100;
    wait_gnt("wd");
    n_cmp++;
    if (o_gnt !== 4'b0100 || o_max_timeout !== 32'd10) begin
      n_bad++;
      $display("FAIL wd_gnt: got gnt=%b to=%0d, required 0100/10", o_gnt, o_max_timeout);
    end
    i_req = '0;
    tick();
`ifdef WAIT_EVENT_ARB_WATCHDOG_EN
    while (o_wait_en && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 27) begin
      n_bad++;
      $display("FAIL wd_wait_len: got %0d WAIT cycles, required 27", n);
    end
    n_cmp++;
    if (o_done !== 4'b0100 || o_err !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_abort: got done=%b err=%b, required 0100/1", o_done, o_err);
    end
`else
    repeat (1000) tick();
    n_cmp++;
    if (o_busy !== 1'b1 || o_wait_en !== 1'b1 || o_done !== '0 || o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_off_hold: got busy=%b en=%b done=%b err=%b, required 1/1/0000/0",
               o_busy, o_wait_en, o_done, o_err);
    end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    i_req = 4'b0010;
    wait_gnt("mid");
    repeat (5) tick();
    n_cmp++;
    if (o_wait_en !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_in_wait: got en=%b, required 1", o_wait_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_gnt, o_done, o_err, o_wait_en, o_busy, o_sel_wtr_wtf} !== '0 ||
        o_wait_sel !== '0 || o_max_timeout !== '0) begin
      n_bad++;
      $display("FAIL mid_async_clear: got gnt=%b done=%b en=%b busy=%b sel=%0d to=%0d, required all 0",
               o_gnt, o_done, o_wait_en, o_busy, o_wait_sel, o_max_timeout);
    end
    tick();
    n_cmp++;
    if (o_done !== '0) begin
      n_bad++;
      $display("FAIL mid_no_done: got %b, required 0000", o_done);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (o_gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL mid_regrant: got %b, required 0010", o_gnt);
    end
    i_req = '0;
    tick();
    i_wait_done = 1'b1;
    tick();
    i_wait_done = 1'b0;
    n_cmp++;
    if (o_done !== 4'b0010) begin
      n_bad++;
      $display("FAIL mid_done: got %b, required 0010", o_done);
    end
    tick();
  endtask

  task automatic test_spurious();
    logic seen_gnt = 1'b0;
    i_wait_done = 1'b1;
    tick();
    n_cmp++;
    if (o_done !== '0 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_done_ignored: got done=%b busy=%b, required 0000/0", o_done, o_busy);
    end
    tick();
    i_wait_done = 1'b0;
    i_req = 4'b0001;
    tick();
    n_cmp++;
    if (o_gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL sp_gnt: got %b, required 0001", o_gnt);
    end
    i_req = 4'b1000;
    tick();
    n_cmp++;
    if (o_wait_en !== 1'b1 || o_done !== '0) begin
      n_bad++;
      $display("FAIL sp_wait: got en=%b done=%b, required 1/0000", o_wait_en, o_done);
    end
    i_req = '0;
    tick();
    i_wait_done = 1'b1;
    tick();
    i_wait_done = 1'b0;
    n_cmp++;
    if (o_done !== 4'b0001) begin
      n_bad++;
      $display("FAIL sp_done: got %b, required 0001", o_done);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_gnt != '0) seen_gnt = 1'b1;
    end
    n_cmp++;
    if (seen_gnt !== 1'b0 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL dropped_req: got granted=%b busy=%b, required 0/0", seen_gnt, o_busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    i_req = '0;
    i_wait_done = 1'b0;
    i_req_sel = '0;
    i_req_edge = 4'b0001;
    i_req_timeout = '0;
    i_req_sel[0*SW +: SW] = 3'd3;
    i_req_sel[1*SW +: SW] = 3'd1;
    i_req_sel[2*SW +: SW] = 3'd2;
    i_req_sel[3*SW +: SW] = 3'd4;
    i_req_timeout[0*TW +: TW] = 32'd100;
    i_req_timeout[1*TW +: TW] = 32'd100;
    i_req_timeout[2*TW +: TW] = 32'd10;
    i_req_timeout[3*TW +: TW] = 32'd100;

    test_reset();
    test_single();
    test_round_robin();
    test_watchdog();
    test_reset_mid_wait();
    test_spurious();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wait_event_arbiter.md
WAIT_EVENT_ARBITER -- requirements
Module: wait_event_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter WAIT_SIZE, default 5, number of watchable signals of the shared wait-event resource.
REQ-003 Parameter TO_WIDTH, default 32, timeout field width in clock cycles.
REQ-004 Port clk  input  1  single clock, all logic on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port i_req  input  N_REQ  per-requester request, level, held until grant.
REQ-007 Port i_req_sel  input  N_REQ*$clog2(WAIT_SIZE)  per-requester signal index.
REQ-008 Port i_req_edge  input  N_REQ  per-requester edge select: 1 = rising (WTR), 0 = falling (WTF).
REQ-009 Port i_req_timeout  input  N_REQ*TO_WIDTH  per-requester timeout.
REQ-010 Port o_gnt  output  N_REQ  one-hot grant pulse, 1 cycle.
REQ-011 Port o_done  output  N_REQ  one-hot completion pulse, 1 cycle.
REQ-012 Port o_err  output  1  qualifies o_done: 1 = aborted by watchdog.
REQ-013 Port o_wait_en  output  1  enable to shared resource, held high for whole wait.
REQ-014 Port o_wait_sel  output  $clog2(WAIT_SIZE)  signal index to resource.
REQ-015 Port o_sel_wtr_wtf  output  1  edge select to resource.
REQ-016 Port o_max_timeout  output  TO_WIDTH  timeout to resource.
REQ-017 Port i_wait_done  input  1  completion from resource, sampled only in WAIT.
REQ-018 Port o_busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states IDLE, GRANT, WAIT, RESP; one-hot or binary is implementer's choice.
REQ-020 IDLE: any i_req bit high -> GRANT next cycle; winner chosen round-robin starting at index last_winner+1 mod N_REQ.
REQ-021 GRANT (1 cycle): o_gnt[winner]=1; winner's sel/edge/timeout latched into o_wait_sel/o_sel_wtr_wtf/o_max_timeout; -> WAIT.
REQ-022 WAIT: o_wait_en=1; config outputs stable; i_wait_done=1 -> RESP.
REQ-023 RESP (1 cycle): o_wait_en=0, o_done[winner]=1, o_err per REQ-030; last_winner updated; -> IDLE.
REQ-024 Latency: i_req rise in IDLE to o_gnt = 1 cycle; i_wait_done to o_done = 1 cycle; minimum 1 idle cycle between consecutive waits (o_wait_en low at least 1 cycle).
REQ-025 Requests arriving in non-IDLE states are not lost; arbitration on return to IDLE.
REQ-026 Requester deasserting i_req before grant is simply not selected; no error.
REQ-027 i_wait_done high in IDLE, GRANT or RESP is ignored.
REQ-028 Round-robin wraps from N_REQ-1 to 0; with all requesters continuously active, each is granted once per N_REQ waits.

Reset
REQ-029 rst_n low: state IDLE, last_winner=N_REQ-1 (index 0 wins first), all outputs 0 including o_wait_en, o_max_timeout, o_wait_sel; reset mid-WAIT aborts wait with no o_done.

Configuration
REQ-030 Macro WAIT_EVENT_ARB_WATCHDOG_EN defined: TO_WIDTH+1-bit cycle counter cleared on WAIT entry; in WAIT, counter = o_max_timeout+16 without i_wait_done -> RESP with o_err=1; done and expiry same cycle -> o_err=0.
REQ-031 Macro undefined: no counter, o_err tied 0, WAIT exits only on i_wait_done.

Structure
REQ-032 Shared package wait_event_pkg holds state typedef and watchdog margin constant (16).
REQ-033 Sub-module wait_event_rr_arbiter: combinational round-robin pick from i_req and last_winner, returns winner index and valid.

Verification
REQ-034 Single request: i_req=0001, sel=3, edge=1, timeout=100; i_wait_done 20 cycles after o_gnt -> o_wait_sel=3, o_sel_wtr_wtf=1, o_done=0001 one cycle after done, o_err=0.
REQ-035 All four requesting continuously, done 5 cycles after each grant -> grant order 0,1,2,3,0; o_wait_en low >=1 cycle between waits.
REQ-036 Watchdog (macro on): timeout=10, no i_wait_done -> o_done with o_err=1 at cycle 26 of WAIT; same with macro off -> still busy after 1000 cycles.
REQ-037 rst_n low 5 cycles into WAIT -> all outputs 0 asynchronously, no o_done; after release, pending request granted normally.
REQ-038 i_wait_done pulsed in IDLE, then request issued -> no spurious o_done; i_req dropped before grant -> never granted.
